// File: rtl/mbist_checker.sv
// MBIST response analyzer: delays each compare strobe by the memory read latency,
// checks it against returned read data, counts mismatches and logs the first one.
module mbist_checker #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              chk_en,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              test_end,
  output logic              fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] ff_addr,
  output logic [DATA_W-1:0] ff_exp,
  output logic [DATA_W-1:0] ff_got,
  output logic              done,
  output logic              pass
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LAST  = RD_LAT - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              drain_cnt_q, drain_cnt_d;
  logic [RD_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_q, pipe_exp_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic                          fail_q, fail_d;
  logic [ERR_W-1:0]              err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]             ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0]             ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0]             ff_got_q, ff_got_d;
  logic                          done_q, done_d;
  logic                          pass_q, pass_d;
  logic                          mism_c;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pipe_vld_d  = '0;
    pipe_exp_d  = '0;
    pipe_addr_d = '0;
    fail_d      = fail_q;
    err_cnt_d   = err_cnt_q;
    ff_addr_d   = ff_addr_q;
    ff_exp_d    = ff_exp_q;
    ff_got_d    = ff_got_q;

    mism_c = pipe_vld_q[LAST] && (rd_data != pipe_exp_q[LAST]);

    // A strobe coincident with start belongs to the new run; older stages are flushed.
    pipe_vld_d[0]  = chk_en && ((state_q == S_RUN) || start);
    pipe_exp_d[0]  = exp_data;
    pipe_addr_d[0] = addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1] && !start;
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start) begin
          state_d = S_RUN;
        end else if (test_end) begin
          state_d     = S_DRAIN;
          drain_cnt_d = CNT_W'(RD_LAT);
        end
      end
      S_DRAIN: begin
        if (start) begin
          state_d = S_RUN;
        end else if (drain_cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      S_DONE: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Logs clear on start; otherwise every mismatch counts and the first is captured.
    if (start) begin
      fail_d    = 1'b0;
      err_cnt_d = '0;
      ff_addr_d = '0;
      ff_exp_d  = '0;
      ff_got_d  = '0;
    end else if (mism_c) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (!fail_q) begin
        fail_d    = 1'b1;
        ff_addr_d = pipe_addr_q[LAST];
        ff_exp_d  = pipe_exp_q[LAST];
        ff_got_d  = rd_data;
      end
    end

    done_d = (state_d == S_DONE);
    pass_d = done_d && !fail_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      pipe_vld_q  <= '0;
      pipe_exp_q  <= '0;
      pipe_addr_q <= '0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      ff_addr_q   <= '0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_exp_q  <= pipe_exp_d;
      pipe_addr_q <= pipe_addr_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      ff_addr_q   <= ff_addr_d;
      ff_exp_q    <= ff_exp_d;
      ff_got_q    <= ff_got_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign fail    = fail_q;
  assign err_cnt = err_cnt_q;
  assign ff_addr = ff_addr_q;
  assign ff_exp  = ff_exp_q;
  assign ff_got  = ff_got_q;
  assign done    = done_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_mbist_checker.sv
// Bench for mbist_checker: one instance at RD_LAT=1/ERR_W=8 and one at RD_LAT=3/ERR_W=4
// share stimulus; a memory model returns data with each instance's latency.
module tb_mbist_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, chk_en, test_end;
  logic [3:0] exp_data;
  logic [7:0] addr;
  logic [3:0] rd1, rd3;
  logic       fail1, fail3, done1, done3, pass1, pass3;
  logic [7:0] err1;
  logic [3:0] err3;
  logic [7:0] ffa1, ffa3;
  logic [3:0] ffe1, ffe3, ffg1, ffg3;

  logic [3:0] mem [256];
  logic [7:0] ah0, ah1, ah2;
  int         cyc   = 0;
  int         n_chk = 0;
  int         n_err = 0;
  logic       fin   = 1'b0;

  mbist_checker #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .ERR_W(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .chk_en(chk_en), .exp_data(exp_data),
    .addr(addr), .rd_data(rd1), .test_end(test_end), .fail(fail1), .err_cnt(err1),
    .ff_addr(ffa1), .ff_exp(ffe1), .ff_got(ffg1), .done(done1), .pass(pass1));

  mbist_checker #(.ADDR_W(8), .DATA_W(4), .RD_LAT(3), .ERR_W(4)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .chk_en(chk_en), .exp_data(exp_data),
    .addr(addr), .rd_data(rd3), .test_end(test_end), .fail(fail3), .err_cnt(err3),
    .ff_addr(ffa3), .ff_exp(ffe3), .ff_got(ffg3), .done(done3), .pass(pass3));

  // Memory model: read data follows the read address by 1 or 3 cycles.
  always @(posedge clk) begin
    ah0 <= addr;
    ah1 <= ah0;
    ah2 <= ah1;
    cyc <= cyc + 1;
  end
  assign rd1 = mem[ah0];
  assign rd3 = mem[ah2];

  typedef struct { int cyc; logic [7:0] a; logic [3:0] e; logic [3:0] g; } fev_t;
  typedef struct {
    int cyc; logic f; logic [7:0] c; logic [7:0] a; logic [3:0] e; logic [3:0] g; logic p;
  } dev_t;
  typedef struct {
    int cyc; int id; int which; logic f; logic [7:0] c;
    logic [7:0] a; logic [3:0] e; logic [3:0] g; logic dn;
  } snap_t;

  fev_t  fq1[$], fq3[$];
  dev_t  dq1[$], dq3[$];
  snap_t sq[$];

  task automatic push_fail(input int which, input int c, input logic [7:0] a,
                           input logic [3:0] e, input logic [3:0] g);
    fev_t v;
    v.cyc = c; v.a = a; v.e = e; v.g = g;
    if (which == 1) fq1.push_back(v); else fq3.push_back(v);
  endtask

  task automatic push_done(input int which, input int c, input logic f, input logic [7:0] cnt,
                           input logic [7:0] a, input logic [3:0] e, input logic [3:0] g,
                           input logic p);
    dev_t v;
    v.cyc = c; v.f = f; v.c = cnt; v.a = a; v.e = e; v.g = g; v.p = p;
    if (which == 1) dq1.push_back(v); else dq3.push_back(v);
  endtask

  task automatic push_snap(input int c, input int id, input int which, input logic f,
                           input logic [7:0] cnt, input logic [7:0] a, input logic [3:0] e,
                           input logic [3:0] g, input logic dn);
    snap_t v;
    v.cyc = c; v.id = id; v.which = which; v.f = f; v.c = cnt;
    v.a = a; v.e = e; v.g = g; v.dn = dn;
    sq.push_back(v);
  endtask

  task automatic snap_clear(input int id);
    push_snap(cyc, id, 1, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0);
    push_snap(cyc, id, 3, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 256-address pass: start with the first strobe, test_end with the last.
  task automatic run_all();
    for (int i = 0; i < 256; i++) begin
      start    = (i == 0);
      chk_en   = 1'b1;
      addr     = 8'(i);
      exp_data = 4'hA;
      test_end = (i == 255);
      tick();
    end
    start    = 1'b0;
    chk_en   = 1'b0;
    test_end = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    rst = 1'b1; start = 1'b0; chk_en = 1'b0; test_end = 1'b0;
    exp_data = 4'hA; addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 4'hA;
    repeat (3) tick();
    snap_clear(1);
    rst = 1'b0;
    tick();

    // Strobes and test_end in IDLE against bad data: nothing may be logged.
    mem[8'h10] = 4'h2;
    addr = 8'h10; chk_en = 1'b1; test_end = 1'b1;
    tick();
    test_end = 1'b0;
    repeat (2) tick();
    chk_en = 1'b0;
    repeat (5) tick();
    snap_clear(2);
    mem[8'h10] = 4'hA;

    // All-pass run.
    s = cyc;
    push_done(1, s + 257, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1);
    push_done(3, s + 259, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1);
    run_all();
    repeat (5) tick();

    // Single fault at 0x37.
    mem[8'h37] = 4'h2;
    s = cyc;
    push_fail(1, s + 8'h37 + 2, 8'h37, 4'hA, 4'h2);
    push_fail(3, s + 8'h37 + 4, 8'h37, 4'hA, 4'h2);
    push_done(1, s + 257, 1'b1, 8'h01, 8'h37, 4'hA, 4'h2, 1'b0);
    push_done(3, s + 259, 1'b1, 8'h01, 8'h37, 4'hA, 4'h2, 1'b0);
    run_all();
    repeat (5) tick();
    mem[8'h37] = 4'hA;

    // 22 mismatches: first-fail hold at 0x05, 4-bit counter saturates.
    mem[8'h05] = 4'h2;
    mem[8'h09] = 4'h3;
    for (int i = 100; i < 120; i++) mem[i] = 4'h0;
    s = cyc;
    push_fail(1, s + 5 + 2, 8'h05, 4'hA, 4'h2);
    push_fail(3, s + 5 + 4, 8'h05, 4'hA, 4'h2);
    push_done(1, s + 257, 1'b1, 8'h16, 8'h05, 4'hA, 4'h2, 1'b0);
    push_done(3, s + 259, 1'b1, 8'h0F, 8'h05, 4'hA, 4'h2, 1'b0);
    run_all();
    repeat (5) tick();
    mem[8'h05] = 4'hA;
    mem[8'h09] = 4'hA;
    for (int i = 100; i < 120; i++) mem[i] = 4'hA;

    // Last strobe (0xFF, with test_end) mismatches and must land during DRAIN.
    mem[8'hFF] = 4'h2;
    s = cyc;
    push_snap(s + 258, 3, 3, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0);
    push_fail(1, s + 255 + 2, 8'hFF, 4'hA, 4'h2);
    push_fail(3, s + 255 + 4, 8'hFF, 4'hA, 4'h2);
    push_done(1, s + 257, 1'b1, 8'h01, 8'hFF, 4'hA, 4'h2, 1'b0);
    push_done(3, s + 259, 1'b1, 8'h01, 8'hFF, 4'hA, 4'h2, 1'b0);
    run_all();
    repeat (5) tick();

    // Strobe in DONE is ignored; results held.
    chk_en = 1'b1; addr = 8'hFF;
    tick();
    chk_en = 1'b0;
    repeat (4) tick();
    push_snap(cyc, 4, 1, 1'b1, 8'h01, 8'hFF, 4'hA, 4'h2, 1'b1);
    push_snap(cyc, 4, 3, 1'b1, 8'h01, 8'hFF, 4'hA, 4'h2, 1'b1);

    // Start from DONE clears everything next cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    snap_clear(5);

    // Reset with strobes in flight: RD_LAT=1 logs the first before reset lands.
    mem[8'h37] = 4'h2;
    mem[8'h38] = 4'h2;
    s = cyc;
    push_fail(1, s + 2, 8'h37, 4'hA, 4'h2);
    chk_en = 1'b1; addr = 8'h37;
    tick();
    addr = 8'h38;
    tick();
    chk_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap_clear(6);
    repeat (6) tick();
    snap_clear(7);
    tick();
    fin = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic f1p = 1'b0, f3p = 1'b0, d1p = 1'b0, d3p = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic chk_fev(input string p, input fev_t v, input logic [7:0] a,
                         input logic [3:0] e, input logic [3:0] g);
    chk({p, " fail rise cycle"}, cyc, v.cyc);
    chk({p, " ff_addr"}, int'(a), int'(v.a));
    chk({p, " ff_exp"}, int'(e), int'(v.e));
    chk({p, " ff_got"}, int'(g), int'(v.g));
  endtask

  task automatic chk_dev(input string p, input dev_t v, input logic f, input logic [7:0] c,
                         input logic [7:0] a, input logic [3:0] e, input logic [3:0] g,
                         input logic ps);
    chk({p, " done cycle"}, cyc, v.cyc);
    chk({p, " fail at done"}, int'(f), int'(v.f));
    chk({p, " err_cnt at done"}, int'(c), int'(v.c));
    chk({p, " ff_addr at done"}, int'(a), int'(v.a));
    chk({p, " ff_exp at done"}, int'(e), int'(v.e));
    chk({p, " ff_got at done"}, int'(g), int'(v.g));
    chk({p, " pass at done"}, int'(ps), int'(v.p));
  endtask

  always @(negedge clk) begin
    snap_t sv;
    if (fail1 === 1'b1 && f1p !== 1'b1) begin
      if (fq1.size() == 0) chk("d1 unexpected fail rise", 1, 0);
      else chk_fev("d1", fq1.pop_front(), ffa1, ffe1, ffg1);
    end
    if (fail3 === 1'b1 && f3p !== 1'b1) begin
      if (fq3.size() == 0) chk("d3 unexpected fail rise", 1, 0);
      else chk_fev("d3", fq3.pop_front(), ffa3, ffe3, ffg3);
    end
    if (done1 === 1'b1 && d1p !== 1'b1) begin
      if (dq1.size() == 0) chk("d1 unexpected done", 1, 0);
      else chk_dev("d1", dq1.pop_front(), fail1, err1, ffa1, ffe1, ffg1, pass1);
    end
    if (done3 === 1'b1 && d3p !== 1'b1) begin
      if (dq3.size() == 0) chk("d3 unexpected done", 1, 0);
      else chk_dev("d3", dq3.pop_front(), fail3, 8'(err3), ffa3, ffe3, ffg3, pass3);
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      sv = sq.pop_front();
      chk($sformatf("snap%0d d%0d cycle", sv.id, sv.which), cyc, sv.cyc);
      if (sv.which == 1) begin
        chk($sformatf("snap%0d d1 fail", sv.id), int'(fail1), int'(sv.f));
        chk($sformatf("snap%0d d1 err_cnt", sv.id), int'(err1), int'(sv.c));
        chk($sformatf("snap%0d d1 ff_addr", sv.id), int'(ffa1), int'(sv.a));
        chk($sformatf("snap%0d d1 ff_exp", sv.id), int'(ffe1), int'(sv.e));
        chk($sformatf("snap%0d d1 ff_got", sv.id), int'(ffg1), int'(sv.g));
        chk($sformatf("snap%0d d1 done", sv.id), int'(done1), int'(sv.dn));
        chk($sformatf("snap%0d d1 pass", sv.id), int'(pass1), int'(sv.dn & ~sv.f));
      end else begin
        chk($sformatf("snap%0d d3 fail", sv.id), int'(fail3), int'(sv.f));
        chk($sformatf("snap%0d d3 err_cnt", sv.id), int'(err3), int'(sv.c));
        chk($sformatf("snap%0d d3 ff_addr", sv.id), int'(ffa3), int'(sv.a));
        chk($sformatf("snap%0d d3 ff_exp", sv.id), int'(ffe3), int'(sv.e));
        chk($sformatf("snap%0d d3 ff_got", sv.id), int'(ffg3), int'(sv.g));
        chk($sformatf("snap%0d d3 done", sv.id), int'(done3), int'(sv.dn));
        chk($sformatf("snap%0d d3 pass", sv.id), int'(pass3), int'(sv.dn & ~sv.f));
      end
    end
    f1p = fail1;
    f3p = fail3;
    d1p = done1;
    d3p = done3;
    if (fin) begin
      chk("d1 fail events outstanding", fq1.size(), 0);
      chk("d3 fail events outstanding", fq3.size(), 0);
      chk("d1 done events outstanding", dq1.size(), 0);
      chk("d3 done events outstanding", dq3.size(), 0);
      chk("snapshots outstanding", sq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end
endmodule
